// File: rtl/klein_pkg.sv
// Shared definitions for the KLEIN-64 core arbiter: FSM encoding, default
// block size and timeout-counter sizing.
package klein_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_WAIT   = 2'd2,
    ST_UNLOAD = 2'd3
  } state_t;

  localparam int NBYTES_DEF  = 8;
  localparam int TIMEOUT_DEF = 255;

  // Width of a counter that must hold values 0..timeout.
  function automatic int tcnt_width(input int timeout);
    if (timeout < 1) begin
      return 1;
    end else begin
      return $clog2(timeout + 1);
    end
  endfunction

  localparam int TCNT_W_DEF = tcnt_width(TIMEOUT_DEF);

endpackage

// File: rtl/klein_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone request wins outright, a tie goes to the
// requester that was not served last.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       pick,
  output logic       valid
);

  // Select the winner among the active requests.
  always_comb begin
    pick  = 1'b0;
    valid = |req;
    case (req)
      2'b01:   pick = 1'b0;
      2'b10:   pick = 1'b1;
      2'b11:   pick = ~last;
      default: pick = 1'b0;
    endcase
  end

endmodule

// File: rtl/klein_arbiter.sv
// Arbitrates two requesters onto one KLEIN-64 core: loads the winner's block,
// waits for the core (with timeout) and streams the ciphertext back.
module klein_arbiter
  import klein_pkg::*;
#(
  parameter int NBYTES  = NBYTES_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic       ck,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic [2:0] byte_idx,
  input  logic [7:0] inp0,
  input  logic [7:0] key0,
  input  logic [7:0] inp1,
  input  logic [7:0] key1,
  output logic       core_start,
  output logic [7:0] core_inp,
  output logic [7:0] core_key,
  input  logic       core_ready,
  input  logic [7:0] core_out,
  output logic [7:0] dout,
  output logic       dout_valid,
  output logic       dout_last,
  output logic       dout_id,
  output logic       err
);

  localparam int         TW       = tcnt_width(TIMEOUT);
  localparam logic [2:0] LAST_IDX = 3'(NBYTES - 1);

  state_t          state_r;
  logic            gid_r;
  logic            last_r;
  logic [1:0]      gnt_r;
  logic [2:0]      byte_idx_r;
  logic [2:0]      ucnt_r;
  logic [TW-1:0]   wcnt_r;
  logic            core_start_r;
  logic [7:0]      dout_r;
  logic            dout_valid_r;
  logic            dout_last_r;
  logic            dout_id_r;
  logic            err_r;
  logic            pick_s;
  logic            pick_valid_s;
  logic [7:0]      core_inp_s;
  logic [7:0]      core_key_s;

  rr_pick2 u_pick (
    .req   (req),
    .last  (last_r),
    .pick  (pick_s),
    .valid (pick_valid_s)
  );

  // Route the granted requester's byte to the core only while loading.
  always_comb begin
    core_inp_s = 8'h00;
    core_key_s = 8'h00;
    if (state_r == ST_LOAD) begin
      core_inp_s = gid_r ? inp1 : inp0;
      core_key_s = gid_r ? key1 : key0;
    end else begin
      core_inp_s = 8'h00;
      core_key_s = 8'h00;
    end
  end

  // Transaction FSM with all control and data outputs registered.
  always_ff @(posedge ck) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      gid_r        <= 1'b0;
      last_r       <= 1'b1;
      gnt_r        <= 2'b00;
      byte_idx_r   <= 3'd0;
      ucnt_r       <= 3'd0;
      wcnt_r       <= '0;
      core_start_r <= 1'b0;
      dout_r       <= 8'h00;
      dout_valid_r <= 1'b0;
      dout_last_r  <= 1'b0;
      dout_id_r    <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      core_start_r <= 1'b0;
      err_r        <= 1'b0;
      dout_r       <= 8'h00;
      dout_valid_r <= 1'b0;
      dout_last_r  <= 1'b0;
      dout_id_r    <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (pick_valid_s) begin
            gid_r        <= pick_s;
            last_r       <= pick_s;
            gnt_r        <= pick_s ? 2'b10 : 2'b01;
            core_start_r <= 1'b1;
            byte_idx_r   <= 3'd0;
            state_r      <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (byte_idx_r == LAST_IDX) begin
            byte_idx_r <= 3'd0;
            wcnt_r     <= TW'(1);
            state_r    <= ST_WAIT;
          end else begin
            byte_idx_r <= byte_idx_r + 3'd1;
          end
        end
        ST_WAIT: begin
          // A ready arriving on the final allowed cycle still wins over abort.
          if (core_ready) begin
            wcnt_r  <= '0;
            ucnt_r  <= 3'd0;
            state_r <= ST_UNLOAD;
          end else if (wcnt_r == TW'(TIMEOUT)) begin
            wcnt_r  <= '0;
            gnt_r   <= 2'b00;
            err_r   <= 1'b1;
            state_r <= ST_IDLE;
          end else begin
            wcnt_r <= wcnt_r + TW'(1);
          end
        end
        ST_UNLOAD: begin
          dout_r       <= core_out;
          dout_valid_r <= 1'b1;
          dout_id_r    <= gid_r;
          dout_last_r  <= (ucnt_r == LAST_IDX);
          if (ucnt_r == LAST_IDX) begin
            ucnt_r  <= 3'd0;
            gnt_r   <= 2'b00;
            state_r <= ST_IDLE;
          end else begin
            ucnt_r <= ucnt_r + 3'd1;
          end
        end
        default: begin
          gnt_r   <= 2'b00;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign gnt        = gnt_r;
  assign byte_idx   = byte_idx_r;
  assign core_start = core_start_r;
  assign core_inp   = core_inp_s;
  assign core_key   = core_key_s;
  assign dout       = dout_r;
  assign dout_valid = dout_valid_r;
  assign dout_last  = dout_last_r;
  assign dout_id    = dout_id_r;
  assign err        = err_r;

endmodule

// File: tb/tb_klein_arbiter.sv
// Self-checking bench for klein_arbiter: directed transaction table, a reset
// sequence, then randomized transactions against a round-robin reference model.
module tb_klein_arbiter;

  localparam int NB = 8;
  localparam int TO = 255;

  logic       ck = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [1:0] gnt;
  logic [2:0] byte_idx;
  logic [7:0] inp0, key0, inp1, key1;
  logic       core_start;
  logic [7:0] core_inp, core_key;
  logic       core_ready;
  logic [7:0] core_out;
  logic [7:0] dout;
  logic       dout_valid, dout_last, dout_id, err;

  klein_arbiter #(.NBYTES(NB), .TIMEOUT(TO)) dut (
    .ck(ck), .rst(rst), .req(req), .gnt(gnt), .byte_idx(byte_idx),
    .inp0(inp0), .key0(key0), .inp1(inp1), .key1(key1),
    .core_start(core_start), .core_inp(core_inp), .core_key(core_key),
    .core_ready(core_ready), .core_out(core_out),
    .dout(dout), .dout_valid(dout_valid), .dout_last(dout_last),
    .dout_id(dout_id), .err(err)
  );

  always #5 ck = ~ck;

  typedef struct {
    logic [1:0] r;
    int         dly;       // WAIT cycle carrying core_ready; 0 = never
    logic [1:0] after;     // req value applied once WAIT starts
    bit         rdy_load;  // stray core_ready pulse during LOAD
    logic [7:0] base;
    int         id;        // expected granted requester
  } vec_t;

  vec_t vecs [9];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   last_served = -1;
  logic [7:0] b0 = 8'h00, k0 = 8'h00, b1 = 8'h00, k1 = 8'h00;
  logic [7:0] ct [NB];

  // Requesters present their block byte selected by byte_idx.
  always_comb begin
    inp0 = b0 + {5'b00000, byte_idx};
    key0 = k0 + {5'b00000, byte_idx};
    inp1 = b1 + {5'b00000, byte_idx};
    key1 = k1 + {5'b00000, byte_idx};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  function automatic int rr_model(input logic [1:0] r);
    if (r == 2'b11) return (last_served == 0) ? 1 : 0;
    else return r[1] ? 1 : 0;
  endfunction

  // Drive one full transaction from an IDLE cycle and check every cycle of it.
  task automatic run_txn(input logic [1:0] r, input int dly, input logic [1:0] after,
                         input bit rdy_load, input logic [7:0] base, input int id);
    logic [1:0] eg;
    logic [7:0] eb, ek;
    eg = (id == 1) ? 2'b10 : 2'b01;
    b0 = base; k0 = base ^ 8'hFF; b1 = base + 8'h40; k1 = base + 8'h80;
    eb = (id == 1) ? b1 : b0;
    ek = (id == 1) ? k1 : k0;
    req = r;
    tick();
    for (int j = 0; j < NB; j++) begin
      core_ready = rdy_load && (j == 3);
      chk("load_gnt", 32'(gnt), 32'(eg));
      chk("load_start", 32'(core_start), (j == 0) ? 32'd1 : 32'd0);
      chk("load_idx", 32'(byte_idx), 32'(j));
      chk("load_inp", 32'(core_inp), 32'(8'(eb + 8'(j))));
      chk("load_key", 32'(core_key), 32'(8'(ek + 8'(j))));
      chk("load_err", 32'(err), 32'd0);
      chk("load_dv", 32'(dout_valid), 32'd0);
      tick();
    end
    core_ready = 1'b0;
    req = after;
    last_served = id;
    for (int k = 1; k <= ((dly == 0) ? TO : dly); k++) begin
      core_ready = (k == dly);
      chk("wait_gnt", 32'(gnt), 32'(eg));
      chk("wait_idx", 32'(byte_idx), 32'd0);
      chk("wait_inp", 32'({core_inp, core_key}), 32'd0);
      chk("wait_dv", 32'(dout_valid), 32'd0);
      chk("wait_err", 32'(err), 32'd0);
      tick();
    end
    core_ready = 1'b0;
    if (dly == 0) begin
      chk("tmo_err", 32'(err), 32'd1);
      chk("tmo_gnt", 32'(gnt), 32'd0);
      chk("tmo_dv", 32'(dout_valid), 32'd0);
      return;
    end
    chk("unl_first_dv", 32'(dout_valid), 32'd0);
    for (int u = 0; u < NB; u++) begin
      ct[u] = 8'($urandom);
      core_out = ct[u];
      tick();
      chk("dout", 32'(dout), 32'(ct[u]));
      chk("dout_valid", 32'(dout_valid), 32'd1);
      chk("dout_last", 32'(dout_last), (u == NB - 1) ? 32'd1 : 32'd0);
      chk("dout_id", 32'(dout_id), 32'(id));
      chk("unl_gnt", 32'(gnt), (u == NB - 1) ? 32'd0 : 32'(eg));
    end
    core_out = 8'h00;
  endtask

  initial begin
    logic [1:0] rr;
    int         dd;
    vecs[0] = '{2'b01, 20, 2'b01, 1'b0, 8'h00, 0};
    vecs[1] = '{2'b11, 3,  2'b11, 1'b0, 8'h11, 1};
    vecs[2] = '{2'b11, 1,  2'b11, 1'b0, 8'h22, 0};
    vecs[3] = '{2'b11, 5,  2'b00, 1'b0, 8'h33, 1};
    vecs[4] = '{2'b01, 7,  2'b00, 1'b0, 8'h44, 0};
    vecs[5] = '{2'b10, 4,  2'b00, 1'b1, 8'h55, 1};
    vecs[6] = '{2'b01, 0,  2'b00, 1'b0, 8'h66, 0};
    vecs[7] = '{2'b11, 2,  2'b00, 1'b0, 8'h77, 1};
    vecs[8] = '{2'b11, TO, 2'b00, 1'b0, 8'h88, 0};

    rst = 1'b1; req = 2'b00; core_ready = 1'b0; core_out = 8'h00;
    tick();
    tick();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_outs", 32'({core_start, dout_valid, dout_last, dout_id, err}), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_idx", 32'(byte_idx), 32'd0);
    chk("rst_core", 32'({core_inp, core_key}), 32'd0);
    rst = 1'b0;

    for (int v = 0; v < 9; v++) begin
      run_txn(vecs[v].r, vecs[v].dly, vecs[v].after, vecs[v].rdy_load, vecs[v].base, vecs[v].id);
    end

    // Reset while byte 3 of a load is on the core port.
    req = 2'b01;
    tick();
    tick(); tick(); tick();
    chk("mid_idx", 32'(byte_idx), 32'd3);
    rst = 1'b1;
    tick();
    chk("mid_rst_gnt", 32'(gnt), 32'd0);
    chk("mid_rst_outs", 32'({core_start, dout_valid, dout_last, dout_id, err}), 32'd0);
    chk("mid_rst_idx", 32'(byte_idx), 32'd0);
    chk("mid_rst_core", 32'({core_inp, core_key}), 32'd0);
    rst = 1'b0;
    req = 2'b00;
    last_served = -1;
    run_txn(2'b10, 6, 2'b00, 1'b0, 8'h99, 1);

    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 2))
        0:       rr = 2'b01;
        1:       rr = 2'b10;
        default: rr = 2'b11;
      endcase
      dd = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 30));
      run_txn(rr, dd, 2'($urandom), 1'($urandom), 8'($urandom), rr_model(rr));
    end

    req = 2'b00;
    tick();
    chk("end_idle_gnt", 32'(gnt), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
